// File: rtl/kb_text_buffer_pkg.sv
// rtl/kb_text_buffer_pkg.sv - shared scan codes, FSM encoding and helpers for kb_text_buffer
package kb_text_pkg;

    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_LSHIFT   = 8'h12;
    localparam logic [7:0] SC_RSHIFT   = 8'h59;
    localparam logic [7:0] SC_BKSP     = 8'h66;
    localparam logic [7:0] SC_ENTER    = 8'h5A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_DECODE,
        ST_WRITE,
        ST_SCROLL
    } state_t;

    function automatic logic is_shift(input logic [7:0] code);
        return (code == SC_LSHIFT) || (code == SC_RSHIFT);
    endfunction

endpackage

// File: rtl/kb_text_buffer_if.sv
// rtl/kb_text_buffer_if.sv - keyboard input, read ports and status of kb_text_buffer
interface kb_text_buffer_if #(
    parameter int AW = 7
);
    logic          kb_valid;
    logic [7:0]    kb_data;
    logic          clear;
    logic [AW-1:0] disp_addr;
    logic [7:0]    disp_char;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_char;
    logic [AW-1:0] cursor;
    logic          busy;
    logic          line_done;
    logic          overflow;

    modport slave (
        input  kb_valid, kb_data, clear, disp_addr, cpu_addr,
        output disp_char, cpu_char, cursor, busy, line_done, overflow
    );

    modport master (
        output kb_valid, kb_data, clear, disp_addr, cpu_addr,
        input  disp_char, cpu_char, cursor, busy, line_done, overflow
    );
endinterface

// File: rtl/kb_text_buffer_ps2_scan_to_ascii.sv
// rtl/kb_text_buffer_ps2_scan_to_ascii.sv - PS/2 set-2 make code plus shift to ASCII, 0 when unmapped
module ps2_scan_to_ascii (
    input  logic [7:0] i_scan,
    input  logic       i_shift,
    output logic [7:0] o_ascii
);
    logic [7:0] w_lo;
    logic [7:0] w_hi;

    always_comb begin
        {w_lo, w_hi} = 16'h0000;
        case (i_scan)
            8'h1C: {w_lo, w_hi} = {"a", "A"};  8'h32: {w_lo, w_hi} = {"b", "B"};
            8'h21: {w_lo, w_hi} = {"c", "C"};  8'h23: {w_lo, w_hi} = {"d", "D"};
            8'h24: {w_lo, w_hi} = {"e", "E"};  8'h2B: {w_lo, w_hi} = {"f", "F"};
            8'h34: {w_lo, w_hi} = {"g", "G"};  8'h33: {w_lo, w_hi} = {"h", "H"};
            8'h43: {w_lo, w_hi} = {"i", "I"};  8'h3B: {w_lo, w_hi} = {"j", "J"};
            8'h42: {w_lo, w_hi} = {"k", "K"};  8'h4B: {w_lo, w_hi} = {"l", "L"};
            8'h3A: {w_lo, w_hi} = {"m", "M"};  8'h31: {w_lo, w_hi} = {"n", "N"};
            8'h44: {w_lo, w_hi} = {"o", "O"};  8'h4D: {w_lo, w_hi} = {"p", "P"};
            8'h15: {w_lo, w_hi} = {"q", "Q"};  8'h2D: {w_lo, w_hi} = {"r", "R"};
            8'h1B: {w_lo, w_hi} = {"s", "S"};  8'h2C: {w_lo, w_hi} = {"t", "T"};
            8'h3C: {w_lo, w_hi} = {"u", "U"};  8'h2A: {w_lo, w_hi} = {"v", "V"};
            8'h1D: {w_lo, w_hi} = {"w", "W"};  8'h22: {w_lo, w_hi} = {"x", "X"};
            8'h35: {w_lo, w_hi} = {"y", "Y"};  8'h1A: {w_lo, w_hi} = {"z", "Z"};
            8'h45: {w_lo, w_hi} = {"0", ")"};  8'h16: {w_lo, w_hi} = {"1", "!"};
            8'h1E: {w_lo, w_hi} = {"2", "@"};  8'h26: {w_lo, w_hi} = {"3", "#"};
            8'h25: {w_lo, w_hi} = {"4", "$"};  8'h2E: {w_lo, w_hi} = {"5", "%"};
            8'h36: {w_lo, w_hi} = {"6", "^"};  8'h3D: {w_lo, w_hi} = {"7", "&"};
            8'h3E: {w_lo, w_hi} = {"8", "*"};  8'h46: {w_lo, w_hi} = {"9", "("};
            8'h0E: {w_lo, w_hi} = {8'h60, "~"};  8'h4E: {w_lo, w_hi} = {"-", "_"};
            8'h55: {w_lo, w_hi} = {"=", "+"};  8'h54: {w_lo, w_hi} = {"[", "{"};
            8'h5B: {w_lo, w_hi} = {"]", "}"};  8'h5D: {w_lo, w_hi} = {"\\", "|"};
            8'h4C: {w_lo, w_hi} = {";", ":"};  8'h52: {w_lo, w_hi} = {"'", "\""};
            8'h41: {w_lo, w_hi} = {",", "<"};  8'h49: {w_lo, w_hi} = {".", ">"};
            8'h4A: {w_lo, w_hi} = {"/", "?"};  8'h29: {w_lo, w_hi} = {" ", " "};
            default: {w_lo, w_hi} = 16'h0000;
        endcase
        o_ascii = i_shift ? w_hi : w_lo;
    end
endmodule

// File: rtl/kb_text_buffer.sv
// rtl/kb_text_buffer.sv - PS/2 byte FIFO, scan-code FSM and COLSxROWS character grid with two read ports
module kb_text_buffer
    import kb_text_pkg::*;
#(
    parameter int COLS        = 12,
    parameter int ROWS        = 9,
    parameter int SCROLL_MODE = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             reset,
    kb_text_buffer_if.slave  bus
);
    localparam int N    = COLS * ROWS;
    localparam int AW   = $clog2(N);
    localparam int AW1  = AW + 1;
    localparam int FAW  = $clog2(FIFO_DEPTH);
    localparam int FAW1 = FAW + 1;

    localparam logic [AW:0]  C_COLS   = AW1'(COLS);
    localparam logic [AW:0]  C_N      = AW1'(N);
    localparam logic [AW:0]  C_LAST   = AW1'((ROWS - 1) * COLS);
    localparam logic [AW:0]  C_COPIES = AW1'(N - COLS);
    localparam logic [FAW:0] C_FDEPTH = FAW1'(FIFO_DEPTH);

    logic [7:0]     r_mem [N];
    logic [7:0]     r_fifo [FIFO_DEPTH];
    logic [FAW-1:0] r_wptr, r_rptr;
    logic [FAW:0]   r_count;
    logic           r_overflow;

    state_t         r_state, w_state;
    logic [AW-1:0]  r_idx, w_idx;
    logic [AW-1:0]  r_cursor, w_cursor;
    logic [AW-1:0]  r_waddr, w_waddr;
    logic [7:0]     r_wdata, w_wdata;
    logic           r_wadv, w_wadv;
    logic [7:0]     r_byte, w_byte;
    logic           r_brk, w_brk, r_ext, w_ext, r_shift, w_shift;
    logic [7:0]     r_disp, r_cpu, r_sdata;

    logic           w_full, w_push, w_pop;
    logic           w_we;
    logic [AW-1:0]  w_mwaddr;
    logic [7:0]     w_mwdata;
    logic           w_line_done;
    logic [7:0]     w_ascii;
    logic [AW:0]    w_cur_x, w_idx_x, w_row_next, w_srd_addr;

    ps2_scan_to_ascii u_scan (
        .i_scan  (r_byte),
        .i_shift (r_shift),
        .o_ascii (w_ascii)
    );

    assign w_full     = (r_count == C_FDEPTH);
    assign w_push     = bus.kb_valid && !w_full;
    assign w_cur_x    = {1'b0, r_cursor};
    assign w_idx_x    = {1'b0, r_idx};
    assign w_row_next = (w_cur_x / C_COLS + AW1'(1)) * C_COLS;
    // The scroll source is fetched one cycle ahead; outside SCROLL it primes cell COLS for cell 0.
    assign w_srd_addr = (r_state == ST_SCROLL) ? (w_idx_x + C_COLS + AW1'(1)) : C_COLS;

    always_comb begin
        w_state     = r_state;
        w_idx       = r_idx;
        w_cursor    = r_cursor;
        w_waddr     = r_waddr;
        w_wdata     = r_wdata;
        w_wadv      = r_wadv;
        w_byte      = r_byte;
        w_brk       = r_brk;
        w_ext       = r_ext;
        w_shift     = r_shift;
        w_pop       = 1'b0;
        w_we        = 1'b0;
        w_mwaddr    = r_idx;
        w_mwdata    = ASCII_SPACE;
        w_line_done = 1'b0;

        case (r_state)
            ST_CLEAR: begin
                w_we = 1'b1;
                if (r_idx == AW'(N - 1)) begin
                    w_state = ST_IDLE;
                    w_idx   = '0;
                end else begin
                    w_idx = r_idx + AW'(1);
                end
            end
            ST_IDLE: begin
                if (r_count != '0) begin
                    w_pop   = 1'b1;
                    w_byte  = r_fifo[r_rptr];
                    w_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_state = ST_IDLE;
                if (r_byte == SC_BREAK) begin
                    w_brk = 1'b1;
                end else if (r_byte == SC_EXT) begin
                    w_ext = 1'b1;
                end else if (r_brk) begin
                    if (is_shift(r_byte)) w_shift = 1'b0;
                    w_brk = 1'b0;
                    w_ext = 1'b0;
                end else if (r_ext) begin
                    w_ext = 1'b0;
                end else if (is_shift(r_byte)) begin
                    w_shift = 1'b1;
                end else if (r_byte == SC_BKSP) begin
                    if (r_cursor != '0) begin
                        w_cursor = r_cursor - AW'(1);
                        w_waddr  = r_cursor - AW'(1);
                        w_wdata  = ASCII_SPACE;
                        w_wadv   = 1'b0;
                        w_state  = ST_WRITE;
                    end
                end else if (r_byte == SC_ENTER) begin
                    w_line_done = 1'b1;
                    if (w_cur_x >= C_LAST) begin
                        if (SCROLL_MODE != 0) begin
                            w_state  = ST_SCROLL;
                            w_idx    = '0;
                            w_cursor = C_LAST[AW-1:0];
                        end else begin
                            w_cursor = '0;
                        end
                    end else begin
                        w_cursor = w_row_next[AW-1:0];
                    end
                end else if (w_ascii != 8'h00) begin
                    w_waddr = r_cursor;
                    w_wdata = w_ascii;
                    w_wadv  = 1'b1;
                    w_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_we     = 1'b1;
                w_mwaddr = r_waddr;
                w_mwdata = r_wdata;
                w_state  = ST_IDLE;
                if (r_wadv) begin
                    if (r_cursor == AW'(N - 1)) begin
                        if (SCROLL_MODE != 0) begin
                            w_state  = ST_SCROLL;
                            w_idx    = '0;
                            w_cursor = C_LAST[AW-1:0];
                        end else begin
                            w_cursor = '0;
                        end
                    end else begin
                        w_cursor = r_cursor + AW'(1);
                    end
                end
            end
            ST_SCROLL: begin
                w_we     = 1'b1;
                w_mwdata = (w_idx_x < C_COPIES) ? r_sdata : ASCII_SPACE;
                if (r_idx == AW'(N - 1)) begin
                    w_state = ST_IDLE;
                    w_idx   = '0;
                end else begin
                    w_idx = r_idx + AW'(1);
                end
            end
            default: w_state = ST_CLEAR;
        endcase

        // clear wins in every state, including a restart of an ongoing CLEAR or SCROLL
        if (bus.clear) begin
            w_state  = ST_CLEAR;
            w_idx    = '0;
            w_cursor = '0;
            w_pop    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_CLEAR;
            r_idx      <= '0;
            r_cursor   <= '0;
            r_waddr    <= '0;
            r_wdata    <= ASCII_SPACE;
            r_wadv     <= 1'b0;
            r_byte     <= 8'h00;
            r_brk      <= 1'b0;
            r_ext      <= 1'b0;
            r_shift    <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_disp     <= ASCII_SPACE;
            r_cpu      <= ASCII_SPACE;
        end else begin
            r_state  <= w_state;
            r_idx    <= w_idx;
            r_cursor <= w_cursor;
            r_waddr  <= w_waddr;
            r_wdata  <= w_wdata;
            r_wadv   <= w_wadv;
            r_byte   <= w_byte;
            r_brk    <= w_brk;
            r_ext    <= w_ext;
            r_shift  <= w_shift;
            if (w_push) r_wptr <= r_wptr + FAW'(1);
            if (w_pop)  r_rptr <= r_rptr + FAW'(1);
            if (w_push && !w_pop)      r_count <= r_count + FAW1'(1);
            else if (!w_push && w_pop) r_count <= r_count - FAW1'(1);
            if (bus.clear)                r_overflow <= 1'b0;
            if (bus.kb_valid && w_full)   r_overflow <= 1'b1;
            r_disp <= ({1'b0, bus.disp_addr} < C_N) ? r_mem[bus.disp_addr] : ASCII_SPACE;
            r_cpu  <= ({1'b0, bus.cpu_addr}  < C_N) ? r_mem[bus.cpu_addr]  : ASCII_SPACE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= bus.kb_data;
        if (w_we)   r_mem[w_mwaddr] <= w_mwdata;
        r_sdata <= (w_srd_addr < C_N) ? r_mem[w_srd_addr[AW-1:0]] : ASCII_SPACE;
    end

    assign bus.disp_char = r_disp;
    assign bus.cpu_char  = r_cpu;
    assign bus.cursor    = r_cursor;
    assign bus.busy      = (r_state == ST_CLEAR) || (r_state == ST_SCROLL);
    assign bus.line_done = w_line_done;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_kb_text_buffer.sv
// tb/tb_kb_text_buffer.sv - directed bench for kb_text_buffer in scroll (u_dut1) and wrap (u_dut0) modes
module tb_kb_text_buffer;
    localparam int AW = 7;
    localparam int N  = 108;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          kb_valid  = 1'b0;
    logic [7:0]    kb_data   = 8'h00;
    logic          clear     = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic [AW-1:0] cpu_addr  = '0;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int bad, cnt, ld;
    logic seen;
    logic [7:0] burst [6] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

    kb_text_buffer_if #(.AW(AW)) u_if1 ();
    kb_text_buffer_if #(.AW(AW)) u_if0 ();

    assign u_if1.kb_valid  = kb_valid;   assign u_if0.kb_valid  = kb_valid;
    assign u_if1.kb_data   = kb_data;    assign u_if0.kb_data   = kb_data;
    assign u_if1.clear     = clear;      assign u_if0.clear     = clear;
    assign u_if1.disp_addr = disp_addr;  assign u_if0.disp_addr = disp_addr;
    assign u_if1.cpu_addr  = cpu_addr;   assign u_if0.cpu_addr  = cpu_addr;

    kb_text_buffer #(.COLS(12), .ROWS(9), .SCROLL_MODE(1), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .reset(reset), .bus(u_if1)
    );
    kb_text_buffer #(.COLS(12), .ROWS(9), .SCROLL_MODE(0), .FIFO_DEPTH(4)) u_dut0 (
        .clk(clk), .reset(reset), .bus(u_if0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        @(negedge clk);
        kb_valid = 1'b1;
        kb_data  = b;
        @(negedge clk);
        kb_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        strobe(b);
        repeat (4) @(negedge clk);
    endtask

    task automatic rd1(input string tag, input int a, input logic [7:0] exp);
        cpu_addr = AW'(a);
        @(negedge clk);
        check(tag, 32'(u_if1.cpu_char), 32'(exp));
    endtask

    task automatic rd0(input string tag, input int a, input logic [7:0] exp);
        cpu_addr = AW'(a);
        @(negedge clk);
        check(tag, 32'(u_if0.cpu_char), 32'(exp));
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 200 && u_if1.busy; i++) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy",      32'(u_if1.busy),      1);
        check("rst_cursor",    32'(u_if1.cursor),    0);
        check("rst_line_done", 32'(u_if1.line_done), 0);
        check("rst_overflow",  32'(u_if1.overflow),  0);
        check("rst_disp_char", 32'(u_if1.disp_char), 32'h20);
        check("rst_cpu_char",  32'(u_if1.cpu_char),  32'h20);

        reset = 1'b0;
        cnt = 0;
        while (u_if1.busy && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        check("clear_cycles", cnt, N);
        bad = 0;
        for (int a = 0; a < N; a++) begin
            cpu_addr = AW'(a);
            @(negedge clk);
            if (u_if1.cpu_char !== 8'h20) bad++;
        end
        check("blank_grid", bad, 0);

        // Latency of a printable make code into cell 0, display port held on it
        disp_addr = '0;
        strobe(8'h1C);
        repeat (3) @(negedge clk);
        check("lat_cursor_t3", 32'(u_if1.cursor), 1);
        check("lat_disp_t3",   32'(u_if1.disp_char), 32'h20);
        @(negedge clk);
        check("lat_disp_t4",   32'(u_if1.disp_char), 32'h61);
        send(8'hF0); send(8'h1C);
        check("break_no_write", 32'(u_if1.cursor), 1);
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h12);
        rd1("shift_upper_A", 1, 8'h41);
        send(8'h32);
        rd1("shift_released_b", 2, 8'h62);
        check("cursor_after_aAb", 32'(u_if1.cursor), 3);
        disp_addr = AW'(N);
        repeat (2) @(negedge clk);
        check("disp_out_of_range", 32'(u_if1.disp_char), 32'h20);
        rd1("cpu_out_of_range", 127, 8'h20);

        do_clear();
        send(8'h1C); send(8'h32); send(8'h66);
        rd1("bksp_cell1", 1, 8'h20);
        rd1("bksp_keeps_cell0", 0, 8'h61);
        check("bksp_cursor", 32'(u_if1.cursor), 1);
        send(8'h66); send(8'h66);
        check("bksp_floor_cursor", 32'(u_if1.cursor), 0);
        rd1("bksp_cell0", 0, 8'h20);

        do_clear();
        send(8'h5A); send(8'h5A);
        check("enter_row2_cursor", 32'(u_if1.cursor), 24);
        strobe(8'h5A);
        ld = 0;
        repeat (8) begin
            @(negedge clk);
            if (u_if1.line_done) ld++;
        end
        check("line_done_pulses", ld, 1);
        check("enter_cursor_36", 32'(u_if1.cursor), 36);

        // Fill the whole grid; the last write triggers SCROLL in mode 1 and a wrap in mode 0
        do_clear();
        repeat (N - 1) send(8'h1C);
        strobe(8'h1C);
        cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (u_if1.busy) begin
                cnt++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        check("scroll_busy_cycles", cnt, N);
        check("wrap_cursor", 32'(u_if0.cursor), 0);
        send(8'h32);
        check("scroll_cursor", 32'(u_if1.cursor), 97);
        check("wrap_cursor_b", 32'(u_if0.cursor), 1);
        rd1("scroll_row0", 0, 8'h61);
        rd1("scroll_row7", 95, 8'h61);
        rd1("scroll_b_96", 96, 8'h62);
        rd1("scroll_blank_97", 97, 8'h20);
        rd1("scroll_blank_107", 107, 8'h20);
        rd0("wrap_b_cell0", 0, 8'h62);
        rd0("wrap_a_cell1", 1, 8'h61);

        // Enter on the last row scrolls again; a 6-byte burst lands during it
        strobe(8'h5A);
        for (int i = 0; i < 10 && !u_if1.busy; i++) @(negedge clk);
        check("enter_scroll_busy", 32'(u_if1.busy), 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            kb_valid = 1'b1;
            kb_data  = burst[i];
        end
        @(negedge clk);
        kb_valid = 1'b0;
        for (int i = 0; i < 200 && u_if1.busy; i++) @(negedge clk);
        repeat (24) @(negedge clk);
        check("burst_overflow", 32'(u_if1.overflow), 1);
        check("burst_cursor", 32'(u_if1.cursor), 100);
        rd1("burst_96", 96, 8'h61);
        rd1("burst_97", 97, 8'h62);
        rd1("burst_98", 98, 8'h63);
        rd1("burst_99", 99, 8'h64);
        rd1("burst_dropped_100", 100, 8'h20);
        rd1("scroll_b_to_84", 84, 8'h62);

        do_clear();
        check("clear_overflow", 32'(u_if1.overflow), 0);
        check("clear_cursor", 32'(u_if1.cursor), 0);
        rd1("clear_cell96", 96, 8'h20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
